// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and the rotate-priority helper for fifo_write_arbiter.
// Optional statistics are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int unsigned STAT_W    = 16;
    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    // First set request after 'last', scanning last+1, last+2, ... modulo n.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                            input int unsigned        last,
                                            input int unsigned        n);
        int unsigned          pick;
        logic                 found;
        logic [MAX_IDX_W-1:0] c;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= n; k++) begin
            c = MAX_IDX_W'((last + k) % n);
            if (!found && req[c]) begin
                pick  = 32'(c);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester, FIFO-write and status signals of fifo_write_arbiter.
// p_stat_count exists only with FIFO_ARB_STATS_EN.
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned BITS  = 32,
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]      p_req;
    logic [N_REQ*BITS-1:0] p_req_data;
    logic [N_REQ-1:0]      p_req_last;
    logic [N_REQ-1:0]      p_ack;
    logic                  p_write_en;
    logic [BITS-1:0]       p_write_data;
    logic                  p_write_full;
    logic [IDX_W-1:0]      p_grant_id;
    logic                  p_busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N_REQ*STAT_W-1:0] p_stat_count;
`endif

    modport master (
        input  p_req, p_req_data, p_req_last, p_write_full,
        output p_ack, p_write_en, p_write_data, p_grant_id, p_busy
`ifdef FIFO_ARB_STATS_EN
        , output p_stat_count
`endif
    );

    modport slave (
        output p_req, p_req_data, p_req_last, p_write_full,
        input  p_ack, p_write_en, p_write_data, p_grant_id, p_busy
`ifdef FIFO_ARB_STATS_EN
        , input p_stat_count
`endif
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_select.sv
// Combinational rotate-priority encoder: picks the first request after 'last'.
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        valid = |req;
        idx   = IDX_W'(rr_pick(MAX_REQ'(req), 32'(last), N_REQ));
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port among N_REQ requesters.
// Define FIFO_ARB_STATS_EN to add saturating per-requester accepted-beat counters.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned BITS      = 32,
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 write_clk,
    input  logic                 write_rst_n,
    fifo_write_arbiter_if.master bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] grant, grant_n;
    logic [IDX_W-1:0] last_grant, last_grant_n;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
    logic             accept;

    rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req   (bus.p_req),
        .last  (last_grant),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            beat_cnt   <= beat_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        beat_cnt_n   = beat_cnt;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    grant_n    = sel_idx;
                    beat_cnt_n = '0;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                if (!bus.p_req[grant]) begin
                    state_n      = IDLE;
                    last_grant_n = grant;
                end else if (!bus.p_write_full) begin
                    accept     = 1'b1;
                    beat_cnt_n = beat_cnt + 1'b1;
                    if (bus.p_req_last[grant] || (beat_cnt == CNT_W'(MAX_BURST - 1))) begin
                        state_n      = IDLE;
                        last_grant_n = grant;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Write strobe is combinational on the registered grant so full is sampled in the write cycle.
    assign bus.p_write_en   = accept;
    assign bus.p_write_data = accept ? bus.p_req_data[grant*BITS +: BITS] : '0;
    assign bus.p_ack        = accept ? (N_REQ'(1) << grant) : '0;
    assign bus.p_grant_id   = grant;
    assign bus.p_busy       = (state == HOLD);

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt [N_REQ];

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            for (int unsigned i = 0; i < N_REQ; i++) stat_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (bus.p_ack[i] && (stat_cnt[i] != '1)) stat_cnt[i] <= stat_cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign bus.p_stat_count[g*STAT_W +: STAT_W] = stat_cnt[g];
    end
`endif

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of `async_fifo` among `N_REQ` write-domain requesters. Runs entirely in the FIFO's write clock domain and drives `p_write_en`/`p_write_data` directly, honouring `p_write_full`. A grant is held for a burst of up to `MAX_BURST` beats, ended early by the requester's `last` marker or by dropping its request. Fairness rotates from the most recently released requester.

## Interface
- `BITS`, 32, width of one FIFO entry; must match the FIFO's `BITS`.
- `N_REQ`, 4, number of requesters; range 2..16.
- `MAX_BURST`, 4, maximum beats per grant; must be ≥1.
- `write_clk`  in  1  single clock; the FIFO write clock.
- `write_rst_n`  in  1  asynchronous, active-low reset.
- `p_req`  in  N_REQ  per-requester write request; data valid while high.
- `p_req_data`  in  N_REQ*BITS  requester data; requester i occupies bits [i*BITS +: BITS].
- `p_req_last`  in  N_REQ  marks requester i's current beat as the end of its burst.
- `p_ack`  out  N_REQ  one-hot pulse; the requester's current beat was written this cycle.
- `p_write_en`  out  1  to FIFO `p_write_en`.
- `p_write_data`  out  BITS  to FIFO `p_write_data`.
- `p_write_full`  in  1  from FIFO `p_write_full`.
- `p_grant_id`  out  $clog2(N_REQ)  index of the current or last owner.
- `p_busy`  out  1  high while in HOLD.
- `p_stat_count`  out  N_REQ*16  accepted-beat counters; present only with `FIFO_ARB_STATS_EN`.

## Operation
- FSM has two states, IDLE and HOLD.
- Registers: `state`, `grant` (index), `last_grant`, `beat_cnt` ($clog2(MAX_BURST)+1 bits).
- IDLE with any `p_req` bit high:
  - Pick the first requester set in rotation order `last_grant+1`, `last_grant+2`, …, wrapping modulo N_REQ.
  - Load `grant`, clear `beat_cnt`, go to HOLD.
  - No write occurs in this cycle.
- HOLD, beat accepted when `p_req[grant] & ~p_write_full`:
  - `p_write_en`=1, `p_write_data`=`p_req_data[grant]`, `p_ack[grant]`=1, `beat_cnt`++.
- HOLD, release to IDLE (sets `last_grant`=`grant`) on any of:
  - An accepted beat with `p_req_last[grant]`=1.
  - An accepted beat that is the MAX_BURST-th beat.
  - `p_req[grant]`=0 (requester abandoned; no write this cycle).
- HOLD with `p_write_full`=1: no write, no ack, `beat_cnt` holds. The grant is held indefinitely (no timeout).
- Write/ack outputs are combinational from the registered `grant`, so `p_write_full` is sampled in the same cycle as the write. Overflow is impossible by construction.
- Non-granted requesters never see `p_ack`. They hold `p_req` and data stable until acked.

## Timing
- Reset values (asserted asynchronously, immediately):
  - `p_write_en`=0, `p_ack`=0, `p_write_data`=0, `p_grant_id`=0, `p_busy`=0.
  - `state`=IDLE, `last_grant`=N_REQ-1, so requester 0 wins first.
  - `p_stat_count`=0.
- Latency from `p_req` rising in IDLE to the first write: 1 cycle.
- Back-to-back grants cost one bubble cycle (the IDLE pick), so peak throughput is MAX_BURST/(MAX_BURST+1).
- `MAX_BURST`=1: every grant is exactly one beat.
- Reset mid-burst: the in-flight beat is not written and not acked; the requester must re-present it.
- A requester that raises `p_req` in the same cycle another is released competes in the next IDLE pick.

## Configuration
- `FIFO_ARB_STATS_EN` defined: adds `p_stat_count`.
  - One 16-bit counter per requester, incremented on each of its acks.
  - Saturates at 16'hFFFF; cleared only by reset.
- `FIFO_ARB_STATS_EN` undefined: the port and counters are absent. Arbitration behaviour is identical.

## Structure
- Package `fifo_arb_pkg` holds:
  - The `arb_state_t` enum (IDLE, HOLD).
  - A `STAT_W`=16 constant.
  - A function returning the rotate-priority pick index from a request vector and `last_grant`.
- Sub-module `rr_select`: combinational rotate-priority encoder (request vector and last index in; index and valid out). The FSM and datapath stay in `fifo_write_arbiter`.

## Test plan
- Reset: hold `write_rst_n`=0 with all `p_req` high -> `p_write_en`=0, `p_ack`=0, `p_busy`=0. Release -> first grant goes to requester 0, first write on cycle 2.
- Round-robin: all 4 requesters request 1 beat with `last`=1 and data 'hA0+i -> FIFO receives A0, A1, A2, A3 in that order, one bubble between each.
- Burst cap: requester 2 streams 10 beats with `last`=0, others idle, MAX_BURST=4 -> pattern of 4 writes, 1 bubble, repeated; `p_ack[2]` pulses 10 times.
- Full stall: force `p_write_full`=1 for 5 cycles mid-burst -> no `p_write_en`, `beat_cnt` frozen, grant kept. On release the burst resumes with no lost or duplicated data.
- Abandon: requester 1 drops `p_req` after 2 of 4 beats -> release in that cycle, and requester 2 is granted next.
- With `FIFO_ARB_STATS_EN`: the above sequences yield counts matching the per-requester ack totals. End-to-end through `async_fifo` with faster write clock, the read data sequence equals the arbitration order.
